// File: rtl/tlm_pkg.sv
// tlm_pkg: shared types, limits and helpers for the timing leak monitor.
`default_nettype none

package tlm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } tlm_state_e;

    localparam int TLM_MAX_CH = 16;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] saturating_inc(input logic [31:0] value,
                                                   input int unsigned width);
        logic [31:0] maxv;
        if (width >= 32) maxv = '1;
        else             maxv = (32'd1 << width) - 32'd1;
        return (value >= maxv) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlm_channel.sv
// tlm_channel: per-channel done edge detect, done-mask bit and latency latch with timeout fill.
`default_nettype none

module tlm_channel
    import tlm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic             done_in,
    input  logic             at_timeout,
    output logic             done_flag,
    output logic [CNT_W-1:0] lat,
    output logic [CNT_W-1:0] lat_nxt
);

    logic             done_d_q;
    logic             mask_q;
    logic             mask_d;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] lat_d;
    logic             w_capture;

    assign w_capture = run & done_in & ~done_d_q & ~mask_q;

    // Timeout fill loads the counter (== MAX_CYCLES) without marking the channel done.
    always_comb begin
        lat_d  = lat_q;
        mask_d = mask_q;
        if (clear) begin
            lat_d  = '0;
            mask_d = 1'b0;
        end else if (w_capture || (at_timeout && !mask_q)) begin
            lat_d  = cnt;
            mask_d = mask_q | w_capture;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_d_q <= 1'b0;
            mask_q   <= 1'b0;
            lat_q    <= '0;
        end else begin
            lat_q  <= lat_d;
            mask_q <= mask_d;
            if (clear || run) done_d_q <= done_in;
        end
    end

    assign done_flag = mask_q | w_capture;
    assign lat       = lat_q;
    assign lat_nxt   = lat_d;

endmodule

`default_nettype wire

// File: rtl/timing_leak_monitor.sv
// timing_leak_monitor: launches NUM_CH multiplier copies together, times each done and
// reports latency, skew, leak/timeout and saturating run statistics.
`default_nettype none

module timing_leak_monitor
    import tlm_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 4096,
    parameter int STAT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic                    dut_start,
    input  logic [NUM_CH-1:0]       dut_done,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    leak,
    output logic                    timeout,
    output logic [CNT_W-1:0]        skew,
    output logic [NUM_CH*CNT_W-1:0] lat_bus,
    output logic [STAT_W-1:0]       run_count,
    output logic [STAT_W-1:0]       leak_count
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    tlm_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              dut_start_q;
    logic              result_valid_q;
    logic              leak_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  skew_q;
    logic [STAT_W-1:0] run_count_q;
    logic [STAT_W-1:0] leak_count_q;

    logic              w_clear;
    logic              w_run;
    logic              w_at_timeout;
    logic [NUM_CH-1:0] w_done_flag;
    logic [CNT_W-1:0]  w_lat     [NUM_CH];
    logic [CNT_W-1:0]  w_lat_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_lat_max;
    logic [CNT_W-1:0]  w_lat_min;
    logic              w_all_done;
    logic              w_timeout;
    logic              w_leak;

    assign w_clear      = (state_q == LAUNCH);
    assign w_run        = (state_q == RUN);
    assign w_at_timeout = w_run && (cnt_q == C_MAX);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tlm_channel #(.CNT_W(CNT_W)) u_channel (
                .clk       (clk),
                .rst       (rst),
                .clear     (w_clear),
                .run       (w_run),
                .cnt       (cnt_q),
                .done_in   (dut_done[gi]),
                .at_timeout(w_at_timeout),
                .done_flag (w_done_flag[gi]),
                .lat       (w_lat[gi]),
                .lat_nxt   (w_lat_nxt[gi])
            );
            assign lat_bus[gi*CNT_W +: CNT_W] = w_lat[gi];
        end
    endgenerate

    // Reduce over next-state latencies so leak/skew register on the same edge as the final captures.
    always_comb begin
        w_lat_max = w_lat_nxt[0];
        w_lat_min = w_lat_nxt[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (w_lat_nxt[i] > w_lat_max) w_lat_max = w_lat_nxt[i];
            if (w_lat_nxt[i] < w_lat_min) w_lat_min = w_lat_nxt[i];
        end
    end

    assign w_all_done = &w_done_flag;
    assign w_timeout  = w_at_timeout & ~w_all_done;
    assign w_leak     = w_timeout | (w_lat_max != w_lat_min);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_ready_q    <= 1'b1;
            dut_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            leak_q         <= 1'b0;
            timeout_q      <= 1'b0;
            skew_q         <= '0;
            run_count_q    <= '0;
            leak_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= LAUNCH;
                        req_ready_q <= 1'b0;
                        dut_start_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state_q     <= RUN;
                    dut_start_q <= 1'b0;
                    cnt_q       <= C_ONE;
                    leak_q      <= 1'b0;
                    timeout_q   <= 1'b0;
                    skew_q      <= '0;
                end
                RUN: begin
                    cnt_q <= cnt_q + C_ONE;
                    if (w_all_done || w_at_timeout) begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                        timeout_q      <= w_timeout;
                        leak_q         <= w_leak;
                        skew_q         <= w_lat_max - w_lat_min;
                        run_count_q    <= STAT_W'(saturating_inc(32'(run_count_q), STAT_W));
                        if (w_leak)
                            leak_count_q <= STAT_W'(saturating_inc(32'(leak_count_q), STAT_W));
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                        req_ready_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign dut_start    = dut_start_q;
    assign result_valid = result_valid_q;
    assign leak         = leak_q;
    assign timeout      = timeout_q;
    assign skew         = skew_q;
    assign run_count    = run_count_q;
    assign leak_count   = leak_count_q;

endmodule

`default_nettype wire

// File: tb/tb_timing_leak_monitor.sv
// tb_timing_leak_monitor: scoreboard bench with directed and random done waveforms.
`default_nettype none

module tb_timing_leak_monitor;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int MAXC = 32;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              result_ready = 1'b0;
    logic [NCH-1:0]    dut_done = '0;
    logic              req_ready;
    logic              dut_start;
    logic              result_valid;
    logic              leak;
    logic              timeout;
    logic [CW-1:0]     skew;
    logic [NCH*CW-1:0] lat_bus;
    logic [SW-1:0]     run_count;
    logic [SW-1:0]     leak_count;

    timing_leak_monitor #(
        .NUM_CH(NCH), .CNT_W(CW), .MAX_CYCLES(MAXC), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .dut_start(dut_start), .dut_done(dut_done), .result_valid(result_valid),
        .result_ready(result_ready), .leak(leak), .timeout(timeout), .skew(skew),
        .lat_bus(lat_bus), .run_count(run_count), .leak_count(leak_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*CW-1:0] lat;
        logic              leak;
        logic              timeout;
        logic [CW-1:0]     skew;
        logic [SW-1:0]     runs;
        logic [SW-1:0]     leaks;
    } res_t;

    res_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         m_runs = 0;
    int         m_leaks = 0;
    int         nres = 0;
    logic [MAXC:0] wv [NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // mode 0 level from L, 1 single-cycle pulse at L, 2 never, 3 held high before start, low at d, high again at L
    task automatic build_wave(input int ch, input int mode, input int l, input int d);
        for (int k = 0; k <= MAXC; k++) begin
            case (mode)
                0: wv[ch][k] = (k >= l);
                1: wv[ch][k] = (k == l);
                2: wv[ch][k] = 1'b0;
                default: wv[ch][k] = (k < d) || (k >= l);
            endcase
        end
    endtask

    function automatic res_t model();
        res_t e;
        int   mx, mn, lt;
        bit   to;
        mx = 0; mn = MAXC + 1; to = 0;
        e = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            lt = -1;
            for (int k = 1; k <= MAXC; k++)
                if (lt < 0 && wv[ch][k] && !wv[ch][k-1]) lt = k;
            if (lt < 0) begin
                lt = MAXC;
                to = 1;
            end
            e.lat[ch*CW +: CW] = CW'(lt);
            if (lt > mx) mx = lt;
            if (lt < mn) mn = lt;
        end
        e.timeout = to;
        e.leak    = to || (mx != mn);
        e.skew    = CW'(mx - mn);
        return e;
    endfunction

    // Returns 1 once dut_start is seen, 0 if the bound expired.
    task automatic launch(output bit ok);
        ok = 0;
        for (int ch = 0; ch < NCH; ch++) dut_done[ch] = wv[ch][0];
        req_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(posedge clk); #1;
            if (dut_start) ok = 1;
        end
        req_valid = 1'b0;
        if (!ok) check("start_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic measure();
        res_t e;
        bit   ok;
        launch(ok);
        if (!ok) return;
        e = model();
        m_runs = (m_runs + 1 > SMAX) ? SMAX : m_runs + 1;
        if (e.leak) m_leaks = (m_leaks + 1 > SMAX) ? SMAX : m_leaks + 1;
        e.runs  = SW'(m_runs);
        e.leaks = SW'(m_leaks);
        exp_q.push_back(e);
        for (int k = 1; k <= MAXC; k++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++) dut_done[ch] = wv[ch][k];
        end
        @(posedge clk); #1;
        dut_done = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_dut_start"}, 64'(dut_start), 64'd0);
        check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_leak_timeout"}, {62'd0, leak, timeout}, 64'd0);
        check({tag, "_skew"}, 64'(skew), 64'd0);
        check({tag, "_lat_bus"}, 64'(lat_bus), 64'd0);
        check({tag, "_stats"}, 64'({run_count, leak_count}), 64'd0);
    endtask

    task automatic reset_mid_run();
        bit ok;
        for (int ch = 0; ch < NCH; ch++) build_wave(ch, 0, 20, 0);
        launch(ok);
        if (!ok) return;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++) dut_done[ch] = wv[ch][k];
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midrun_reset");
        rst = 1'b1;
        dut_done = '0;
        m_runs  = 0;
        m_leaks = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_no_result", 64'(result_valid), 64'd0);
    endtask

    // Monitor: pops on each new result, then checks the fields stay held until accepted.
    initial begin : monitor
        res_t e;
        res_t snap;
        bit   have;
        int   hold;
        have = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                if (!have) begin
                    have = 1;
                    snap = {lat_bus, leak, timeout, skew, run_count, leak_count};
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'd0, 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        for (int ch = 0; ch < NCH; ch++)
                            check($sformatf("lat%0d", ch), 64'(lat_bus[ch*CW +: CW]), 64'(e.lat[ch*CW +: CW]));
                        check("leak", 64'(leak), 64'(e.leak));
                        check("timeout", 64'(timeout), 64'(e.timeout));
                        check("skew", 64'(skew), 64'(e.skew));
                        check("run_count", 64'(run_count), 64'(e.runs));
                        check("leak_count", 64'(leak_count), 64'(e.leaks));
                    end
                    hold = (nres == 3) ? 40 : (($urandom % 8 == 0) ? 20 : int'($urandom_range(0, 3)));
                    nres++;
                end else begin
                    check("result_held", 64'({lat_bus, leak, timeout, skew, run_count, leak_count} != snap), 64'd0);
                end
                check("req_ready_in_done", 64'({req_ready, dut_start}), 64'd0);
                if (hold == 0) result_ready = 1'b1;
                else hold--;
            end else begin
                have = 0;
                result_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int md;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int ch = 0; ch < NCH; ch++) build_wave(ch, 0, 10, 0);
        measure();
        build_wave(2, 0, 12, 0);
        measure();
        build_wave(2, 0, 10, 0);
        build_wave(3, 2, 0, 0);
        measure();
        build_wave(3, 0, MAXC, 0);
        measure();
        for (int ch = 0; ch < NCH; ch++) build_wave(ch, 0, 5, 0);
        measure();

        reset_mid_run();

        build_wave(0, 1, 8, 0);
        build_wave(1, 3, 8, 3);
        build_wave(2, 0, 8, 0);
        build_wave(3, 0, 8, 0);
        measure();
        build_wave(1, 3, MAXC + 1, MAXC + 1);
        measure();

        for (int r = 0; r < 40; r++) begin
            base = int'($urandom_range(1, 12));
            for (int ch = 0; ch < NCH; ch++) begin
                md = int'($urandom_range(0, 15));
                if (md == 15)      build_wave(ch, 2, 0, 0);
                else if (md == 14) build_wave(ch, 0, int'($urandom_range(30, MAXC)), 0);
                else if (md >= 11) build_wave(ch, 3, base + 2, int'($urandom_range(1, base + 1)));
                else if (md >= 8)  build_wave(ch, 1, base + int'($urandom_range(0, 3)), 0);
                else               build_wave(ch, 0, base, 0);
            end
            measure();
        end

        for (int n = 0; n < 300 && (exp_q.size() != 0 || result_valid); n++) @(posedge clk);
        #1;
        check("drain_results", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
